// File: rtl/ahb_mtx_pkg.sv
// rtl/ahb_mtx_pkg.sv - shared AHB bus-matrix codes, default-slave state encoding and clog2 helper
package ahb_mtx_pkg;

    // HTRANS codes
    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    // HRESP codes
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    // Default-slave FSM: ERR1 is the wait beat, ERR2 the final error beat
    typedef enum logic [1:0] {
        DFT_IDLE = 2'b00,
        DFT_ERR1 = 2'b01,
        DFT_ERR2 = 2'b10
    } dft_state_e;

    // Ceiling log2, usable in parameter expressions
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ahb_mtx_dft_slave.sv
// rtl/ahb_mtx_dft_slave.sv - AHB default slave giving a two-cycle ERROR to unmapped NONSEQ/SEQ
module ahb_mtx_dft_slave
    import ahb_mtx_pkg::*;
(
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       sel,
    input  logic [1:0] trans,
    input  logic       ready_in,
    output logic       readyout,
    output logic [1:0] resp
);

    dft_state_e state;
    logic       start;

    // IDLE and BUSY never start an error; only an accepted NONSEQ/SEQ does
    assign start = sel & ready_in & trans[1];

    // State and registered outputs move together so readyout/resp are glitch-free
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state    <= DFT_IDLE;
            readyout <= 1'b1;
            resp     <= RESP_OKAY;
        end else begin
            case (state)
                DFT_IDLE, DFT_ERR2: begin
                    if (start) begin
                        state    <= DFT_ERR1;
                        readyout <= 1'b0;
                        resp     <= RESP_ERROR;
                    end else begin
                        state    <= DFT_IDLE;
                        readyout <= 1'b1;
                        resp     <= RESP_OKAY;
                    end
                end
                DFT_ERR1: begin
                    state    <= DFT_ERR2;
                    readyout <= 1'b1;
                    resp     <= RESP_ERROR;
                end
                default: begin
                    state    <= DFT_IDLE;
                    readyout <= 1'b1;
                    resp     <= RESP_OKAY;
                end
            endcase
        end
    end

endmodule

// File: rtl/ahb_mtx_decoder.sv
// rtl/ahb_mtx_decoder.sv - N-port bus-matrix address decoder with response mux; AHB_DEC_ERRLOG_EN adds unmapped-access log
module ahb_mtx_decoder
    import ahb_mtx_pkg::*;
#(
    parameter int                      NUM_PORTS    = 4,
    parameter logic [22*NUM_PORTS-1:0] REGION_BASE  = {NUM_PORTS{22'h0}},
    parameter logic [22*NUM_PORTS-1:0] REGION_LIMIT = {NUM_PORTS{22'h3f}},
    parameter int                      ERR_CNT_W    = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [21:0]               decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic [NUM_PORTS-1:0]      active_vec,
    input  logic [NUM_PORTS-1:0]      readyout_vec,
    input  logic [2*NUM_PORTS-1:0]    resp_vec,
    input  logic [32*NUM_PORTS-1:0]   rdata_vec,
    output logic [NUM_PORTS-1:0]      sel_vec,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [31:0]               HRDATAS
`ifdef AHB_DEC_ERRLOG_EN
    ,
    input  logic                      err_clr,
    output logic [ERR_CNT_W-1:0]      err_count,
    output logic [21:0]               err_addr
`endif
);

    localparam int          PW  = clog2(NUM_PORTS + 1);
    localparam logic [PW-1:0] DFT = PW'(NUM_PORTS);

    logic [PW-1:0] addr_port;
    logic [PW-1:0] data_port;
    logic          region_hit;
    logic          dft_sel;
    logic          dft_readyout;
    logic [1:0]    dft_resp;

    // Region match: scanning downwards lets the lowest matching index win; inverted regions never match
    always_comb begin
        addr_port  = DFT;
        region_hit = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 0; p--) begin
            if ((decode_addr_dec >= REGION_BASE[22*p +: 22]) &&
                (decode_addr_dec <= REGION_LIMIT[22*p +: 22])) begin
                addr_port  = PW'(p);
                region_hit = 1'b1;
            end
        end
        // An unmapped IDLE stays with the current owner instead of waking the default slave
        if (!region_hit && (trans_dec == TRANS_IDLE)) begin
            addr_port = data_port;
        end
    end

    // Address-phase selects and active flag; the default slave counts as always active
    always_comb begin
        sel_vec    = '0;
        active_dec = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            sel_vec[p] = sel_dec & (addr_port == PW'(p));
            if (addr_port == PW'(p)) begin
                active_dec = active_vec[p];
            end
        end
    end

    assign dft_sel = sel_dec & (addr_port == DFT);

    // Data-phase owner advances only when the input stage completes the address phase
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            data_port <= '0;
        end else if (HREADYS) begin
            data_port <= addr_port;
        end
    end

    // Response mux back to the master; the default slave returns zero read data
    always_comb begin
        HREADYOUTS = dft_readyout;
        HRESPS     = dft_resp;
        HRDATAS    = 32'h0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (data_port == PW'(p)) begin
                HREADYOUTS = readyout_vec[p];
                HRESPS     = resp_vec[2*p +: 2];
                HRDATAS    = rdata_vec[32*p +: 32];
            end
        end
    end

    ahb_mtx_dft_slave u_dft_slave (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .sel      (dft_sel),
        .trans    (trans_dec),
        .ready_in (HREADYS),
        .readyout (dft_readyout),
        .resp     (dft_resp)
    );

`ifdef AHB_DEC_ERRLOG_EN
    logic err_event;

    // readyout is low only in ERR1, so this is exactly a transition from IDLE/ERR2 into ERR1
    assign err_event = dft_sel & HREADYS & trans_dec[1] & dft_readyout;

    // Saturating unmapped-access log; a same-cycle event overrides the clear and restarts at 1
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            err_count <= '0;
            err_addr  <= '0;
        end else if (err_event) begin
            if (err_clr) begin
                err_count <= ERR_CNT_W'(1);
            end else if (err_count != {ERR_CNT_W{1'b1}}) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
            err_addr <= decode_addr_dec;
        end else if (err_clr) begin
            err_count <= '0;
            err_addr  <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_mtx_decoder.sv
// tb/tb_ahb_mtx_decoder.sv - self-checking bench for ahb_mtx_decoder against a behavioural model
module tb_ahb_mtx_decoder;

    localparam int NP     = 4;
    localparam int DFTIDX = NP;
    localparam int CW     = 2;
    localparam int CMAX   = 3;

    logic          HCLK;
    logic          HRESET;
    logic          HREADYS;
    logic          sel_dec;
    logic [21:0]   decode_addr_dec;
    logic [1:0]    trans_dec;
    logic [NP-1:0] active_vec;
    logic [NP-1:0] readyout_vec;
    logic [2*NP-1:0]  resp_vec;
    logic [32*NP-1:0] rdata_vec;
    logic [NP-1:0] sel_vec;
    logic          active_dec;
    logic          HREADYOUTS;
    logic [1:0]    HRESPS;
    logic [31:0]   HRDATAS;
    logic          err_clr;
    logic [CW-1:0] err_count;
    logic [21:0]   err_addr;

    // second instance: overlapping and inverted regions
    logic [21:0]   o_addr;
    logic [2:0]    o_active_vec;
    logic [2:0]    o_sel_vec;
    logic          o_active_dec;
    logic          o_rdy;
    logic [1:0]    o_resp;
    logic [31:0]   o_rdata;
    logic [15:0]   o_err_count;
    logic [21:0]   o_err_addr;

    int total;
    int bad;

    // reference model state
    logic [21:0] m_base  [NP] = '{22'h140000, 22'h140040, 22'h140080, 22'h1400c0};
    logic [21:0] m_limit [NP] = '{22'h14003f, 22'h14007f, 22'h1400bf, 22'h1400ff};
    logic [21:0] ov_base [3]  = '{22'h10, 22'h00, 22'h10};
    logic [21:0] ov_limit[3]  = '{22'h05, 22'h20, 22'h30};
    int          m_owner;
    int          m_beat;   // 0: no error response, 1: wait beat, 2: final error beat
    int          m_cnt;
    logic [21:0] m_addr;
    bit          all_ready;

    ahb_mtx_decoder #(
        .NUM_PORTS    (NP),
        .REGION_BASE  ({22'h1400c0, 22'h140080, 22'h140040, 22'h140000}),
        .REGION_LIMIT ({22'h1400ff, 22'h1400bf, 22'h14007f, 22'h14003f}),
        .ERR_CNT_W    (CW)
    ) dut (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .HREADYS         (HREADYS),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .active_vec      (active_vec),
        .readyout_vec    (readyout_vec),
        .resp_vec        (resp_vec),
        .rdata_vec       (rdata_vec),
        .sel_vec         (sel_vec),
        .active_dec      (active_dec),
        .HREADYOUTS      (HREADYOUTS),
        .HRESPS          (HRESPS),
        .HRDATAS         (HRDATAS)
`ifdef AHB_DEC_ERRLOG_EN
        ,
        .err_clr         (err_clr),
        .err_count       (err_count),
        .err_addr        (err_addr)
`endif
    );

    ahb_mtx_decoder #(
        .NUM_PORTS    (3),
        .REGION_BASE  ({22'h10, 22'h00, 22'h10}),
        .REGION_LIMIT ({22'h30, 22'h20, 22'h05})
    ) dut_ovl (
        .HCLK            (HCLK),
        .HRESET          (HRESET),
        .HREADYS         (1'b0),
        .sel_dec         (1'b1),
        .decode_addr_dec (o_addr),
        .trans_dec       (2'b10),
        .active_vec      (o_active_vec),
        .readyout_vec    (3'b111),
        .resp_vec        (6'b0),
        .rdata_vec       (96'h0),
        .sel_vec         (o_sel_vec),
        .active_dec      (o_active_dec),
        .HREADYOUTS      (o_rdy),
        .HRESPS          (o_resp),
        .HRDATAS         (o_rdata)
`ifdef AHB_DEC_ERRLOG_EN
        ,
        .err_clr         (1'b0),
        .err_count       (o_err_count),
        .err_addr        (o_err_addr)
`endif
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_decode(input logic [21:0] a, input logic [1:0] t, input int owner);
        for (int p = 0; p < NP; p++)
            if (a >= m_base[p] && a <= m_limit[p]) return p;
        return (t == 2'b00) ? owner : DFTIDX;
    endfunction

    function automatic logic [21:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 22'h140000;
            1: return 22'h14003f;
            2: return 22'h140040;
            3: return 22'h1400ff;
            4: return 22'h140100;
            5: return 22'h13ffff;
            6: return 22'h140000 + 22'($urandom_range(0, 255));
            default: return 22'($urandom);
        endcase
    endfunction

    task automatic randomize_slaves();
        active_vec   = 4'($urandom);
        readyout_vec = 4'($urandom) | (all_ready ? 4'hf : 4'h0);
        resp_vec     = 8'($urandom) & 8'h55;
        rdata_vec    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        sel_dec = 1'b0;
        trans_dec = 2'b00;
        decode_addr_dec = 22'h0;
        err_clr = 1'b0;
        HREADYS = 1'b1;
        m_owner = 0;
        m_beat = 0;
        m_cnt = 0;
        m_addr = 22'h0;
        #1;
        chk("rst_ready", 32'(HREADYOUTS), 32'(readyout_vec[0]));
        chk("rst_resp", 32'(HRESPS), 32'(resp_vec[1:0]));
        chk("rst_rdata", HRDATAS, rdata_vec[31:0]);
`ifdef AHB_DEC_ERRLOG_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_err_addr", 32'(err_addr), 32'd0);
`endif
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic do_cycle(input logic s, input logic [21:0] a, input logic [1:0] t, input logic clr);
        int          ap;
        logic [3:0]  e_sel;
        logic        e_act;
        logic        e_rdy;
        logic [1:0]  e_resp;
        logic [31:0] e_rd;
        logic        start;
        @(negedge HCLK);
        randomize_slaves();
        sel_dec = s;
        decode_addr_dec = a;
        trans_dec = t;
        err_clr = clr;
        ap = model_decode(a, t, m_owner);
        if (m_owner == DFTIDX) begin
            e_rdy  = (m_beat != 1);
            e_resp = (m_beat != 0) ? 2'b01 : 2'b00;
            e_rd   = 32'h0;
        end else begin
            e_rdy  = readyout_vec[m_owner];
            e_resp = resp_vec[2*m_owner +: 2];
            e_rd   = rdata_vec[32*m_owner +: 32];
        end
        HREADYS = e_rdy;
        e_sel = (s && ap < NP) ? 4'(1 << ap) : 4'b0;
        e_act = (ap == DFTIDX) ? 1'b1 : active_vec[ap];
        #1;
        chk("sel_vec", 32'(sel_vec), 32'(e_sel));
        chk("active_dec", 32'(active_dec), 32'(e_act));
        chk("HREADYOUTS", 32'(HREADYOUTS), 32'(e_rdy));
        chk("HRESPS", 32'(HRESPS), 32'(e_resp));
        chk("HRDATAS", HRDATAS, e_rd);
`ifdef AHB_DEC_ERRLOG_EN
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("err_addr", 32'(err_addr), 32'(m_addr));
`endif
        // advance the model to the state after the coming rising edge
        start = s && (ap == DFTIDX) && e_rdy && t[1] && (m_beat != 1);
        m_beat = (m_beat == 1) ? 2 : (start ? 1 : 0);
        if (e_rdy) m_owner = ap;
        if (start) begin
            m_cnt  = clr ? 1 : ((m_cnt < CMAX) ? m_cnt + 1 : CMAX);
            m_addr = a;
        end else if (clr) begin
            m_cnt  = 0;
            m_addr = 22'h0;
        end
    endtask

    initial begin
        logic [2:0]  ov_exp;
        logic        ov_act;
        logic [21:0] ov_pts[5];
        total = 0;
        bad = 0;
        all_ready = 1'b1;
        HRESET = 1'b1;
        HREADYS = 1'b1;
        sel_dec = 1'b0;
        decode_addr_dec = 22'h0;
        trans_dec = 2'b00;
        err_clr = 1'b0;
        o_addr = 22'h0;
        o_active_vec = 3'b101;
        randomize_slaves();

        do_reset();

        // mapped NONSEQ to port 1, then its data phase
        do_cycle(1'b1, 22'h140050, 2'b10, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // unmapped NONSEQ: two-beat error response
        do_cycle(1'b1, 22'h200000, 2'b10, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // IDLE to unmapped address stays on port 2
        do_cycle(1'b1, 22'h140090, 2'b10, 1'b0);
        do_cycle(1'b1, 22'h300000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // IDLE and BUSY owned by the default slave get zero-wait OKAY
        do_cycle(1'b1, 22'h300000, 2'b10, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b1, 22'h300004, 2'b00, 1'b0);
        do_cycle(1'b1, 22'h300004, 2'b01, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // clear, then back-to-back unmapped NONSEQ accepted on ERR2
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b1);
        do_cycle(1'b1, 22'h200004, 2'b10, 1'b0);
        do_cycle(1'b1, 22'h200008, 2'b10, 1'b0);
        do_cycle(1'b1, 22'h200008, 2'b11, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // clear coincident with an event
        do_cycle(1'b1, 22'h20000c, 2'b10, 1'b1);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // five events saturate a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            do_cycle(1'b1, 22'h210000 + 22'(i), 2'b10, 1'b0);
            do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
            do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);
        end
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // reset asserted during ERR1
        do_cycle(1'b1, 22'h220000, 2'b10, 1'b0);
        do_reset();
        do_cycle(1'b0, 22'h000000, 2'b00, 1'b0);

        // randomized traffic with slaves inserting wait states
        all_ready = 1'b0;
        for (int i = 0; i < 400; i++) begin
            do_cycle(1'($urandom), pick_addr(), 2'($urandom), ($urandom_range(0, 15) == 0));
        end
        all_ready = 1'b1;

        // overlap resolves to the lowest index; inverted region 0 never matches
        ov_pts = '{22'h05, 22'h10, 22'h25, 22'h31, 22'h20};
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            o_addr = ov_pts[i];
            ov_exp = 3'b000;
            ov_act = 1'b1;
            for (int p = 2; p >= 0; p--) begin
                if (ov_pts[i] >= ov_base[p] && ov_pts[i] <= ov_limit[p]) begin
                    ov_exp = 3'(1 << p);
                    ov_act = o_active_vec[p];
                end
            end
            #1;
            chk("ovl_sel_vec", 32'(o_sel_vec), 32'(ov_exp));
            chk("ovl_active", 32'(o_active_dec), 32'(ov_act));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
